// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter_ctrl sequencer: command opcodes and FSM states.
package counter_ctrl_pkg;

  localparam int unsigned CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_START  = 2'd0,
    CMD_PAUSE  = 2'd1,
    CMD_RESUME = 2'd2,
    CMD_ABORT  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : counter_ctrl_pkg

// File: rtl/counter_ctrl_prescaler.sv
// Tick divider: emits one tick every (i_div+1) enabled cycles; count is held while disabled.
// Only instantiated when COUNTER_CTRL_PRESCALE_EN is defined.
module counter_ctrl_prescaler
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_div,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] cnt_q;

  assign o_tick = i_en && (cnt_q == i_div);

  // Divider count: cleared on restart, wraps to 0 on each tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clear) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= o_tick ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

endmodule : counter_ctrl_prescaler

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for an up-counter with programmable compare-match,
// one-shot or auto-reload. Optional tick prescaler enabled by COUNTER_CTRL_PRESCALE_EN.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [CMD_W-1:0]      i_cmd_op,
  input  logic [WIDTH-1:0]      i_cmd_limit,
  input  logic                  i_cmd_reload,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_running,
  output logic                  o_done,
  output logic                  o_match,
  output logic                  o_cmd_err
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  limit_q, limit_d;
  logic              reload_q, reload_d;
  logic              ready_q;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              match_q, match_d;
  logic              err_q, err_d;

  logic              acc_c;
  cmd_e              op_c;
  logic              start_c;
  logic              abort_c;
  logic              tick_c;
  logic              match_ev_c;
  logic              err_ev_c;

  assign acc_c   = i_cmd_valid && ready_q;
  assign op_c    = cmd_e'(i_cmd_op);
  assign start_c = acc_c && (op_c == CMD_START);
  assign abort_c = acc_c && (op_c == CMD_ABORT);

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q;

  // Divisor is latched with the START that launches the run.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prescale_q <= '0;
    end else if (start_c) begin
      prescale_q <= i_prescale;
    end
  end

  counter_ctrl_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (start_c || abort_c),
    .i_en    (state_q == ST_RUN),
    .i_div   (prescale_q),
    .o_tick  (tick_c)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^i_prescale;
  assign tick_c          = (state_q == ST_RUN);
`endif

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      limit_q  <= '0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      reload_q <= reload_d;
    end
  end

  // Next state: START/ABORT override a coincident tick; PAUSE lets the tick land first.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    reload_d   = reload_q;
    match_ev_c = 1'b0;
    err_ev_c   = 1'b0;
    if (start_c) begin
      state_d  = ST_RUN;
      count_d  = '0;
      limit_d  = i_cmd_limit;
      reload_d = i_cmd_reload;
    end else if (abort_c) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      if (tick_c) begin
        if (count_q == limit_q) begin
          match_ev_c = 1'b1;
          if (reload_q) begin
            count_d = '0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      if (acc_c && (op_c == CMD_PAUSE)) begin
        if (state_q != ST_RUN) begin
          err_ev_c = 1'b1;
        end else if (state_d == ST_RUN) begin
          state_d = ST_PAUSE;
        end
      end
      if (acc_c && (op_c == CMD_RESUME)) begin
        if (state_q == ST_PAUSE) begin
          state_d = ST_RUN;
        end else begin
          err_ev_c = 1'b1;
        end
      end
    end
  end

  // Output decode from the upcoming state and this cycle's events.
  always_comb begin
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
    match_d   = match_ev_c;
    err_d     = err_ev_c;
  end

  // Output registers; ready rises on the first edge out of reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ready_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      running_q <= running_d;
      done_q    <= done_d;
      match_q   <= match_d;
      err_q     <= err_d;
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_count     = count_q;
  assign o_running   = running_q;
  assign o_done      = done_q;
  assign o_match     = match_q;
  assign o_cmd_err   = err_q;

endmodule : counter_ctrl

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: stimulus pushes model expectations, a monitor pops and compares.
module tb_counter_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 4;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_PAUSE  = 2'd1;
  localparam logic [1:0] OP_RESUME = 2'd2;
  localparam logic [1:0] OP_ABORT  = 2'd3;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_e;

  typedef struct packed {
    logic [W-1:0] count;
    logic         running;
    logic         done;
    logic         match;
    logic         err;
    logic         ready;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_limit;
  logic          cmd_reload;
  logic [PW-1:0] prescale;
  logic [W-1:0]  count;
  logic          running;
  logic          done;
  logic          match;
  logic          cmd_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  exp_t exp_q[$];

  // Reference model state
  mode_e       m_mode  = M_IDLE;
  int unsigned m_count = 0;
  int unsigned m_lim   = 0;
  bit          m_rel   = 0;
  int unsigned m_pre   = 0;
  int unsigned m_pcnt  = 0;
  bit          m_ready = 0;

  counter_ctrl #(
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_op     (cmd_op),
    .i_cmd_limit  (cmd_limit),
    .i_cmd_reload (cmd_reload),
    .i_prescale   (prescale),
    .o_count      (count),
    .o_running    (running),
    .o_done       (done),
    .o_match      (match),
    .o_cmd_err    (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int unsigned act, input int unsigned want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, want);
    end
  endfunction

  // Behavioural model: one clock edge worth of the command/tick rules.
  task automatic model_step(input bit rst, input bit v, input logic [1:0] op,
                            input int unsigned lim, input bit rel, input int unsigned pre);
    exp_t  e;
    mode_e prev;
    bit    acc, tick, mt, er;
    mt = 0;
    er = 0;
    if (!rst) begin
      m_mode = M_IDLE; m_count = 0; m_lim = 0; m_rel = 0;
      m_pre = 0; m_pcnt = 0; m_ready = 0;
    end else begin
      acc     = v && m_ready;
      m_ready = 1;
      prev    = m_mode;
      tick    = (m_mode == M_RUN);
`ifdef COUNTER_CTRL_PRESCALE_EN
      tick = tick && (m_pcnt == m_pre);
      if (m_mode == M_RUN) m_pcnt = (m_pcnt == m_pre) ? 0 : m_pcnt + 1;
`endif
      if (acc && op == OP_START) begin
        m_mode = M_RUN; m_count = 0; m_lim = lim; m_rel = rel; m_pre = pre; m_pcnt = 0;
      end else if (acc && op == OP_ABORT) begin
        m_mode = M_IDLE; m_count = 0; m_pcnt = 0;
      end else begin
        if (tick) begin
          if (m_count == m_lim) begin
            mt = 1;
            if (m_rel) m_count = 0;
            else m_mode = M_DONE;
          end else begin
            m_count = m_count + 1;
          end
        end
        if (acc && op == OP_PAUSE) begin
          if (prev != M_RUN) er = 1;
          else if (m_mode == M_RUN) m_mode = M_PAUSE;
        end
        if (acc && op == OP_RESUME) begin
          if (prev == M_PAUSE) m_mode = M_RUN;
          else er = 1;
        end
      end
    end
    e.count   = W'(m_count);
    e.running = (m_mode == M_RUN);
    e.done    = (m_mode == M_DONE);
    e.match   = mt;
    e.err     = er;
    e.ready   = m_ready;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, record the expectation, advance past the edge.
  task automatic step(input bit rst, input bit v, input logic [1:0] op,
                      input int unsigned lim, input bit rel, input int unsigned pre);
    rst_n      = rst;
    cmd_valid  = v;
    cmd_op     = op;
    cmd_limit  = W'(lim);
    cmd_reload = rel;
    prescale   = PW'(pre);
    model_step(rst, v, op, lim, rel, pre);
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, OP_START, 0, 0, 0);
  endtask

  task automatic cmd(input logic [1:0] op, input int unsigned lim, input bit rel, input int unsigned pre);
    step(1, 1, op, lim, rel, pre);
  endtask

  // Monitor: outputs are presented every cycle; compare one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count",   32'(count),     32'(e.count));
        check("running", 32'(running),   32'(e.running));
        check("done",    32'(done),      32'(e.done));
        check("match",   32'(match),     32'(e.match));
        check("cmd_err", 32'(cmd_err),   32'(e.err));
        check("ready",   32'(cmd_ready), 32'(e.ready));
      end
    end
  end

  initial begin
    int unsigned lim, pre;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_limit = '0; cmd_reload = 1'b0; prescale = '0;

    // Power-on reset, then reset asserted for 3 cycles mid-run
    for (int i = 0; i < 3; i++) step(0, 0, OP_START, 0, 0, 0);
    cmd(OP_START, 7, 1, 0);
    idle(4);
    for (int i = 0; i < 3; i++) step(0, 0, OP_START, 0, 0, 0);
    idle(3);

    // Auto-reload limit=3
    cmd(OP_START, 3, 1, 0);
    idle(12);

    // One-shot limit=2
    cmd(OP_START, 2, 0, 0);
    idle(6);

    // Pause at count 4 for 5 cycles, resume to match at 9
    cmd(OP_START, 9, 0, 0);
    idle(3);
    cmd(OP_PAUSE, 0, 0, 0);
    idle(5);
    cmd(OP_RESUME, 0, 0, 0);
    idle(8);

    // Illegal commands: PAUSE in IDLE, RESUME in RUN, PAUSE in DONE
    cmd(OP_ABORT, 0, 0, 0);
    cmd(OP_PAUSE, 0, 0, 0);
    idle(1);
    cmd(OP_START, 5, 1, 0);
    idle(1);
    cmd(OP_RESUME, 0, 0, 0);
    idle(2);
    cmd(OP_START, 0, 0, 0);
    idle(2);
    cmd(OP_PAUSE, 0, 0, 0);
    idle(1);

    // ABORT on the matching tick, limit=1 reload
    cmd(OP_START, 1, 1, 0);
    idle(1);
    cmd(OP_ABORT, 0, 0, 0);
    idle(2);

    // START on the matching tick discards it
    cmd(OP_START, 1, 1, 0);
    idle(1);
    cmd(OP_START, 2, 1, 0);
    idle(2);

    // PAUSE coinciding with a one-shot match: match fires, DONE, no error
    cmd(OP_START, 2, 0, 0);
    idle(2);
    cmd(OP_PAUSE, 0, 0, 0);
    idle(2);

    // limit=0 matches every tick; prescale=2 paces it under the macro
    cmd(OP_START, 0, 1, 0);
    idle(4);
    cmd(OP_START, 4, 1, 2);
    idle(16);

    // Full-range limit with reload
    cmd(OP_START, (1 << W) - 1, 1, 0);
    idle(260);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      lim = ($urandom_range(0, 9) == 0) ? (1 << W) - 1 : $urandom_range(0, 9);
      pre = $urandom_range(0, 3);
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < 25),
           2'($urandom_range(0, 3)), lim, 1'($urandom_range(0, 1)), pre);
    end

    // Drain: every pushed expectation must have been compared
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_counter_ctrl
